// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM arbiter: FSM state encoding, port ids and default widths.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int ADDR_W_DEF   = 21;
    localparam int DATA_W_DEF   = 256;
    localparam int MAX_SKIP_DEF = 4;
    localparam int CNT_W_DEF    = 32;

endpackage

// File: rtl/sdram_arb_stats.sv
// Grant and busy-cycle counters for the SDRAM arbiter; 1-cycle update latency, wrap at 2^CNT_W.
// No backpressure: every strobe is counted in the cycle it is presented.
module sdram_arb_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grant_p0,
    input  logic             grant_p1,
    input  logic             busy,
    output logic [CNT_W-1:0] stat_p0,
    output logic [CNT_W-1:0] stat_p1,
    output logic [CNT_W-1:0] stat_busy
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_p0   <= '0;
            stat_p1   <= '0;
            stat_busy <= '0;
        end else begin
            if (grant_p0) stat_p0 <= stat_p0 + CNT_W'(1);
            if (grant_p1) stat_p1 <= stat_p1 + CNT_W'(1);
            if (busy)     stat_busy <= stat_busy + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter onto one SDRAM line controller: port 0 priority, port 1 served after MAX_SKIP skips.
// Start->sdc_start 1 cycle, sdc_done->pN_done 1 cycle; requesters hold pN_start until pN_done. SDRAM_ARB_STATS_EN adds counters.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_SKIP = MAX_SKIP_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_start,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p0_we,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_q,
    input  logic              p1_start,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              p1_we,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_q,
    output logic              sdc_start,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data,
    output logic              sdc_we,
    input  logic              sdc_done,
    input  logic [DATA_W-1:0] sdc_q,
    output logic [CNT_W-1:0]  stat_p0,
    output logic [CNT_W-1:0]  stat_p1,
    output logic [CNT_W-1:0]  stat_busy
);

    localparam int SKIP_W = $clog2(MAX_SKIP + 1);

    arb_state_t        state, state_nxt;
    logic              grant;
    logic [SKIP_W-1:0] skip;
    logic              winner;
    logic              grant_now;
    logic              resp_now;

    // Port 1 overrides port 0 only once it has been passed over MAX_SKIP times in a row.
    always_comb begin
        winner = PORT0;
        if (p1_start && (!p0_start || skip == SKIP_W'(MAX_SKIP))) winner = PORT1;
    end

    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        resp_now  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (p0_start || p1_start) begin
                    grant_now = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (sdc_done) begin
                    resp_now  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= PORT0;
            skip      <= '0;
            sdc_start <= 1'b0;
            sdc_addr  <= '0;
            sdc_data  <= '0;
            sdc_we    <= 1'b0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            p0_q      <= '0;
            p1_q      <= '0;
        end else begin
            sdc_start <= grant_now;
            p0_done   <= resp_now && (grant == PORT0);
            p1_done   <= resp_now && (grant == PORT1);
            if (grant_now) begin
                grant    <= winner;
                sdc_addr <= (winner == PORT1) ? p1_addr : p0_addr;
                sdc_data <= (winner == PORT1) ? p1_data : p0_data;
                sdc_we   <= (winner == PORT1) ? p1_we   : p0_we;
            end
            // Skip count only tracks a continuously waiting port 1.
            if (state == ST_IDLE) begin
                if (!p1_start || (grant_now && winner == PORT1)) skip <= '0;
                else if (grant_now)                              skip <= skip + SKIP_W'(1);
            end
            if (resp_now && grant == PORT0) p0_q <= sdc_q;
            if (resp_now && grant == PORT1) p1_q <= sdc_q;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic stat_g0, stat_g1, stat_bz;
    assign stat_g0 = grant_now && (winner == PORT0);
    assign stat_g1 = grant_now && (winner == PORT1);
    assign stat_bz = (state != ST_IDLE);

    sdram_arb_stats #(.CNT_W(CNT_W)) u_stats (
        .clk       (clk),
        .reset     (reset),
        .grant_p0  (stat_g0),
        .grant_p1  (stat_g1),
        .busy      (stat_bz),
        .stat_p0   (stat_p0),
        .stat_p1   (stat_p1),
        .stat_busy (stat_busy)
    );
`else
    assign stat_p0   = '0;
    assign stat_p1   = '0;
    assign stat_busy = '0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed requests, a latency-programmable controller model and a transaction-level reference.
module tb_sdram_arbiter;

    localparam int AW = 21;
    localparam int DW = 256;
    localparam int MS = 4;
    localparam int CW = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
    } req_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p0_start = 1'b0, p1_start = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_data = '0, p1_data = '0;
    logic          p0_we = 1'b0, p1_we = 1'b0;
    logic          p0_done, p1_done;
    logic [DW-1:0] p0_q, p1_q;
    logic          sdc_start;
    logic [AW-1:0] sdc_addr;
    logic [DW-1:0] sdc_data;
    logic          sdc_we;
    logic          sdc_done = 1'b0;
    logic [DW-1:0] sdc_q = '0;
    logic [CW-1:0] stat_p0, stat_p1, stat_busy;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_SKIP(MS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .p0_start(p0_start), .p0_addr(p0_addr), .p0_data(p0_data), .p0_we(p0_we),
        .p0_done(p0_done), .p0_q(p0_q),
        .p1_start(p1_start), .p1_addr(p1_addr), .p1_data(p1_data), .p1_we(p1_we),
        .p1_done(p1_done), .p1_q(p1_q),
        .sdc_start(sdc_start), .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we),
        .sdc_done(sdc_done), .sdc_q(sdc_q),
        .stat_p0(stat_p0), .stat_p1(stat_p1), .stat_busy(stat_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {11'h0, a} ^ 32'h5A00_0000;
        return {8{w}};
    endfunction

    // ---------------- controller model (not reset, like the real one) ----------------
    int            ctl_lat = 6;
    int            ctl_cnt = 0;
    logic          ctl_fixed = 1'b0;
    logic [AW-1:0] ctl_addr = '0;

    always @(posedge clk) begin
        #1;
        sdc_done = 1'b0;
        if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) begin
                sdc_done = 1'b1;
                sdc_q    = ctl_fixed ? {32{8'hA5}} : line_of(ctl_addr);
            end
        end
        if (sdc_start) begin
            ctl_cnt  = ctl_lat;
            ctl_addr = sdc_addr;
        end
    end

    // ---------------- requesters ----------------
    req_t rq0[32];
    req_t rq1[32];
    int   n0 = 0, n1 = 0;
    int   h0 = 0, h1 = 0;
    logic drop = 1'b0;
    logic d0 = 1'b0, d1 = 1'b0;
    int   t_req0 = 0;
    int   cyc = 0;

    always @(posedge clk) begin
        #2;
        if (drop) begin
            p0_start = 1'b0;
            p1_start = 1'b0;
            h0 = n0;
            h1 = n1;
        end else begin
            if (p0_start && d0) p0_start = 1'b0;
            if (p1_start && d1) p1_start = 1'b0;
            if (!p0_start && h0 != n0) begin
                p0_addr = rq0[h0].a; p0_data = rq0[h0].d; p0_we = rq0[h0].we;
                p0_start = 1'b1; h0++; t_req0 = cyc;
            end
            if (!p1_start && h1 != n1) begin
                p1_addr = rq1[h1].a; p1_data = rq1[h1].d; p1_we = rq1[h1].we;
                p1_start = 1'b1; h1++;
            end
        end
    end

    // ---------------- reference model: one transfer at a time, timestamps per transfer ----------------
    logic          chk_en = 1'b0;
    logic          m_act = 1'b0, m_got = 1'b0;
    int            m_port = 0, m_issue = 0, m_done_cyc = 0, m_skip = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_q0 = '0, m_q1 = '0;
    logic          m_we = 1'b0;
    int            m_g0 = 0, m_g1 = 0, m_busy = 0;
    int            m_glog[128];
    int            m_ng = 0;

    always @(posedge clk) begin
        int c;
        int w;
        c = cyc;
        cyc = cyc + 1;
        if (reset) begin
            chk_en = 1'b1;
            m_act = 1'b0; m_got = 1'b0; m_skip = 0;
            m_addr = '0; m_data = '0; m_we = 1'b0; m_q0 = '0; m_q1 = '0;
            m_g0 = 0; m_g1 = 0; m_busy = 0;
        end else if (!m_act) begin
            if (p0_start || p1_start) begin
                w = (p1_start && (!p0_start || m_skip == MS)) ? 1 : 0;
                if (!p1_start || w == 1) m_skip = 0;
                else m_skip = m_skip + 1;
                m_act = 1'b1; m_got = 1'b0; m_port = w; m_issue = c + 1;
                m_addr = w ? p1_addr : p0_addr;
                m_data = w ? p1_data : p0_data;
                m_we   = w ? p1_we   : p0_we;
                if (w == 1) m_g1++; else m_g0++;
                if (m_ng < 128) begin m_glog[m_ng] = w; m_ng++; end
            end else begin
                m_skip = 0;
            end
        end else begin
            m_busy++;
            if (!m_got) begin
                if (c > m_issue && sdc_done) begin
                    m_got = 1'b1;
                    m_done_cyc = c + 1;
                    if (m_port == 0) m_q0 = sdc_q; else m_q1 = sdc_q;
                end
            end else if (c == m_done_cyc) begin
                m_act = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare and observation ----------------
    int            n_start = 0, n_done = 0;
    int            done_log[128];
    int            t_start_last = 0, t_done_last = 0, t_done0 = 0;
    logic [AW-1:0] cap_addr_s = '0, cap_addr_d = '0;
    logic [DW-1:0] cap_data_s = '0, cap_data_d = '0;
    logic          cap_we_s = 1'b0, cap_we_d = 1'b0;

    always @(negedge clk) begin
        d0 = p0_done;
        d1 = p1_done;
        if (chk_en) begin
            check("sdc_start", sdc_start, m_act && !m_got && cyc == m_issue);
            check("sdc_addr", sdc_addr, m_addr);
            check("sdc_data", sdc_data, m_data);
            check("sdc_we", sdc_we, m_we);
            check("p0_done", p0_done, m_act && m_got && cyc == m_done_cyc && m_port == 0);
            check("p1_done", p1_done, m_act && m_got && cyc == m_done_cyc && m_port == 1);
            check("p0_q", p0_q, m_q0);
            check("p1_q", p1_q, m_q1);
`ifdef SDRAM_ARB_STATS_EN
            check("stat_p0", stat_p0, CW'(m_g0));
            check("stat_p1", stat_p1, CW'(m_g1));
            check("stat_busy", stat_busy, CW'(m_busy));
`else
            check("stat_p0", stat_p0, '0);
            check("stat_p1", stat_p1, '0);
            check("stat_busy", stat_busy, '0);
`endif
        end
        if (sdc_start === 1'b1) begin
            n_start++; t_start_last = cyc;
            cap_addr_s = sdc_addr; cap_data_s = sdc_data; cap_we_s = sdc_we;
        end
        if (sdc_done) begin
            cap_addr_d = sdc_addr; cap_data_d = sdc_data; cap_we_d = sdc_we;
        end
        if (p0_done === 1'b1 && n_done < 128) begin
            done_log[n_done] = 0; n_done++; t_done0 = cyc; t_done_last = cyc;
        end
        if (p1_done === 1'b1 && n_done < 128) begin
            done_log[n_done] = 1; n_done++; t_done_last = cyc;
        end
    end

    // ---------------- directed tests ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        rq0[n0].a = a; rq0[n0].d = d; rq0[n0].we = we; n0++;
    endtask

    task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        rq1[n1].a = a; rq1[n1].d = d; rq1[n1].we = we; n1++;
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        int   n;
        logic timed_out;
        n = 0;
        while ((h0 != n0 || h1 != n1 || p0_start || p1_start || m_act) && n < budget) begin
            step(1);
            n++;
        end
        timed_out = (n >= budget);
        check(nm, timed_out, 1'b0);
        step(3);
    endtask

    int            exp3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int            bd, bs, bg, nw;
    logic [DW-1:0] ones;
    logic          ok;

    initial begin
        ones = '1;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        check("rst_sdc_start", sdc_start, 1'b0);
        check("rst_sdc_addr", sdc_addr, '0);
        check("rst_p0_done", p0_done, 1'b0);
        check("rst_p1_q", p1_q, '0);
        check("rst_stat_busy", stat_busy, '0);

        // 1: single p0 read, controller answers 6 cycles after sdc_start
        ctl_fixed = 1'b1; ctl_lat = 6;
        bs = n_start; bd = n_done;
        push0(21'h00010, '0, 1'b0);
        wait_quiet("t1_timeout", 100);
        check("t1_n_start", n_start - bs, 1);
        check("t1_n_done", n_done - bd, 1);
        check("t1_done_port", done_log[bd], 0);
        check("t1_p0_q", p0_q, {32{8'hA5}});
        check("t1_req_to_start", t_start_last - t_req0, 1);
        check("t1_start_to_done", t_done_last - t_start_last, 7);
        ctl_fixed = 1'b0;

        // 2: simultaneous requests, p0 first
        bd = n_done; bg = m_ng;
        push0(21'h00100, '0, 1'b0);
        push1(21'h00200, '0, 1'b0);
        wait_quiet("t2_timeout", 200);
        check("t2_n_done", n_done - bd, 2);
        check("t2_first", done_log[bd], 0);
        check("t2_second", done_log[bd + 1], 1);
        check("t2_model_first", m_glog[bg], 0);
        check("t2_model_second", m_glog[bg + 1], 1);
        ok = (t_start_last > t_done0);
        check("t2_p1_after_p0_done", ok, 1'b1);
        check("t2_p0_q", p0_q, line_of(21'h00100));
        check("t2_p1_q", p1_q, line_of(21'h00200));

        // 3: p0 saturated, p1 held: four p0 grants per p1 grant
        bd = n_done; bg = m_ng;
        push1(21'h01000, '0, 1'b0);
        push1(21'h01001, '0, 1'b0);
        for (int i = 0; i < 8; i++) push0(AW'(21'h02000 + i), '0, 1'b0);
        wait_quiet("t3_timeout", 600);
        check("t3_n_done", n_done - bd, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t3_done_%0d", i), done_log[bd + i], exp3[i]);
            check($sformatf("t3_model_%0d", i), m_glog[bg + i], exp3[i]);
        end

        // 4: p1 write at the top address
        bd = n_done;
        push1(21'h1FFFFF, ones, 1'b1);
        wait_quiet("t4_timeout", 100);
        check("t4_addr_issue", cap_addr_s, 21'h1FFFFF);
        check("t4_we_issue", cap_we_s, 1'b1);
        check("t4_data_issue", cap_data_s, ones);
        check("t4_addr_done", cap_addr_d, 21'h1FFFFF);
        check("t4_we_done", cap_we_d, 1'b1);
        check("t4_data_done", cap_data_d, ones);
        check("t4_done_port", done_log[bd], 1);

        // 5: reset while waiting; stray sdc_done arrives in IDLE
        ctl_lat = 5;
        bd = n_done; bs = n_start;
        push0(21'h00033, '0, 1'b0);
        nw = 0;
        while (n_start == bs && nw < 50) begin step(1); nw++; end
        ok = (nw >= 50);
        check("t5_issue_timeout", ok, 1'b0);
        step(2);
        reset = 1'b1; drop = 1'b1;
        step(1);
        reset = 1'b0;
        step(8);
        drop = 1'b0;
        check("t5_no_done", n_done - bd, 0);
        check("t5_no_reissue", n_start - bs, 1);
        check("t5_p0_q_cleared", p0_q, '0);
        ctl_lat = 6;
        push0(21'h00044, '0, 1'b0);
        wait_quiet("t5_timeout", 100);
        check("t5_after_done", n_done - bd, 1);
        check("t5_after_q", p0_q, line_of(21'h00044));

        // 6: statistics over 3 p0 + 2 p1 transfers, 8 busy cycles each
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) push0(AW'(21'h00500 + i), '0, 1'b0);
        for (int i = 0; i < 2; i++) push1(AW'(21'h00600 + i), ones, 1'b1);
        wait_quiet("t6_timeout", 400);
`ifdef SDRAM_ARB_STATS_EN
        check("t6_stat_p0", stat_p0, 3);
        check("t6_stat_p1", stat_p1, 2);
        check("t6_stat_busy", stat_busy, 40);
`else
        check("t6_stat_p0", stat_p0, 0);
        check("t6_stat_p1", stat_p1, 0);
        check("t6_stat_busy", stat_busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
